// File: rtl/dot_product_sequencer.sv
// Control sequencer that streams operand pairs into an external
// multiply-accumulate data_path and returns one result per run.
module dot_product_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  vec_len,
   output logic                  busy,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_A,
   input  logic [DATA_WIDTH-1:0] in_B,
   output logic                  in_ready,
   output logic                  dp_reset_n,
   output logic [DATA_WIDTH-1:0] dp_inData_A,
   output logic [DATA_WIDTH-1:0] dp_inData_B,
   output logic                  dp_en_Mux,
   output logic                  dp_en_PPReg,
   output logic                  dp_en_FDReg,
   input  logic [DATA_WIDTH-1:0] dp_outData,
   input  logic                  dp_resultIsInvalid,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic                  res_invalid
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ACCUM   = 2'd1;
   localparam logic [1:0] S_WAIT_FD = 2'd2;
   localparam logic [1:0] S_HOLD    = 2'd3;

   localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

   logic [1:0]            state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
   logic                  res_inv_q, res_inv_d;

   logic hs;
   logic last;

   // Outputs are masked by reset so an in-flight state is invisible
   // during the reset cycle itself.
   assign busy       = ~reset & (state_q != S_IDLE);
   assign in_ready   = ~reset & (state_q == S_ACCUM);
   assign res_valid  = ~reset & (state_q == S_HOLD);
   assign dp_reset_n = ~reset;

   assign hs   = in_valid & in_ready;
   assign last = (cnt_q == (len_q - ONE));

   assign dp_inData_A = hs ? in_A : '0;
   assign dp_inData_B = hs ? in_B : '0;
   assign dp_en_PPReg = hs;
   assign dp_en_Mux   = hs & (cnt_q != '0);
   assign dp_en_FDReg = hs & last;

   assign res_data    = res_data_q;
   assign res_invalid = res_inv_q;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      res_data_d = res_data_q;
      res_inv_d  = res_inv_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && (vec_len != '0)) begin
               state_d = S_ACCUM;
               len_d   = vec_len;
               cnt_d   = '0;
            end
         end
         S_ACCUM: begin
            if (hs) begin
               if (last) state_d = S_WAIT_FD;
               else      cnt_d   = cnt_q + ONE;
            end
         end
         S_WAIT_FD: begin
            res_data_d = dp_outData;
            res_inv_d  = dp_resultIsInvalid;
            state_d    = S_HOLD;
         end
         S_HOLD: begin
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         cnt_q      <= '0;
         res_data_q <= '0;
         res_inv_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         res_data_q <= res_data_d;
         res_inv_q  <= res_inv_d;
      end
   end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer with a behavioral MAC data_path
// model and a result scoreboard.
module tb_dot_product_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] vec_len;
   logic       busy;
   logic       in_valid;
   logic [7:0] in_A, in_B;
   logic       in_ready;
   logic       dp_reset_n;
   logic [7:0] dp_inData_A, dp_inData_B;
   logic       dp_en_Mux, dp_en_PPReg, dp_en_FDReg;
   logic [7:0] dp_outData;
   logic       dp_resultIsInvalid;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_invalid;

   always #5 clk = ~clk;

   dot_product_sequencer #(.DATA_WIDTH(8), .LEN_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .vec_len(vec_len),
      .busy(busy), .in_valid(in_valid), .in_A(in_A), .in_B(in_B),
      .in_ready(in_ready), .dp_reset_n(dp_reset_n),
      .dp_inData_A(dp_inData_A), .dp_inData_B(dp_inData_B),
      .dp_en_Mux(dp_en_Mux), .dp_en_PPReg(dp_en_PPReg),
      .dp_en_FDReg(dp_en_FDReg), .dp_outData(dp_outData),
      .dp_resultIsInvalid(dp_resultIsInvalid), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data),
      .res_invalid(res_invalid)
   );

   // Accumulator restarts when en_Mux=0; final register loads on en_FDReg.
   logic [31:0] acc_q, fd_q, nxt;
   assign nxt = (dp_en_Mux ? acc_q : 32'd0)
              + (32'(dp_inData_A) * 32'(dp_inData_B));
   always @(posedge clk) begin
      if (!dp_reset_n) begin
         acc_q <= 32'd0;
         fd_q  <= 32'd0;
      end else begin
         if (dp_en_PPReg) acc_q <= nxt;
         if (dp_en_FDReg) fd_q  <= nxt;
      end
   end
   assign dp_outData         = fd_q[7:0];
   assign dp_resultIsInvalid = |fd_q[31:8];

   typedef struct {
      int             len;
      logic [3:0][7:0] a;
      logic [3:0][7:0] b;
      int             gap;
      int             hold;
      logic [7:0]     exp_d;
      logic           exp_i;
   } vec_t;

   typedef struct packed {
      logic [7:0] d;
      logic       i;
   } res_t;

   res_t sbq[$];
   vec_t tbl[4];
   int   total = 0;
   int   bad   = 0;

   task automatic chk1(input string n, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", n, act, exp);
      end
   endtask

   task automatic chk8(input string n, input logic [7:0] act,
                       input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", n, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input int len,
      input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3,
      input int gap, input int hold,
      input logic [7:0] d, input logic i);
      vec_t v;
      v.len = len;
      v.a = {a3, a2, a1, a0};
      v.b = {b3, b2, b1, b0};
      v.gap = gap;
      v.hold = hold;
      v.exp_d = d;
      v.exp_i = i;
      return v;
   endfunction

   // Entered just after a rising edge with the DUT idle; leaves it the same.
   task automatic run_vec(input vec_t v);
      res_t r;
      res_t e;
      start = 1'b1;
      vec_len = 4'(v.len);
      @(negedge clk);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_ready", in_ready, 1'b0);
      cyc();
      start = 1'b0;
      for (int i = 0; i < v.len; i++) begin
         in_valid = 1'b1;
         in_A = v.a[i];
         in_B = v.b[i];
         @(negedge clk);
         chk1("acc_ready", in_ready, 1'b1);
         chk1("en_pp", dp_en_PPReg, 1'b1);
         chk1("en_mux", dp_en_Mux, i != 0);
         chk1("en_fd", dp_en_FDReg, i == v.len - 1);
         chk8("dp_A", dp_inData_A, v.a[i]);
         chk8("dp_B", dp_inData_B, v.b[i]);
         if (i == v.len - 1) begin
            e.d = v.exp_d;
            e.i = v.exp_i;
            sbq.push_back(e);
         end
         cyc();
         in_valid = 1'b0;
         in_A = 8'hFF;
         in_B = 8'hFF;
         if (i == 0 && v.len > 1) begin
            for (int g = 0; g < v.gap; g++) begin
               @(negedge clk);
               chk1("gap_busy", busy, 1'b1);
               chk1("gap_pp", dp_en_PPReg, 1'b0);
               chk1("gap_mux", dp_en_Mux, 1'b0);
               chk1("gap_fd", dp_en_FDReg, 1'b0);
               chk8("gap_A", dp_inData_A, 8'd0);
               cyc();
            end
         end
      end
      in_A = 8'd0;
      in_B = 8'd0;
      @(negedge clk);
      chk1("wfd_valid", res_valid, 1'b0);
      chk1("wfd_busy", busy, 1'b1);
      cyc();
      for (int h = 0; h <= v.hold; h++) begin
         res_ready = (h == v.hold);
         start = (h == 1) || (h == v.hold);
         vec_len = 4'd3;
         @(negedge clk);
         chk1("hold_valid", res_valid, 1'b1);
         if (h == 0) begin
            total++;
            if (sbq.size() == 0) begin
               bad++;
               $display("FAIL sb_empty: got none want one");
               r = '0;
            end else begin
               r = sbq.pop_front();
            end
            chk8("res_data", res_data, r.d);
            chk1("res_inv", res_invalid, r.i);
         end else begin
            chk8("hold_data", res_data, v.exp_d);
         end
         cyc();
      end
      res_ready = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk1("post_busy", busy, 1'b0);
      chk1("post_valid", res_valid, 1'b0);
      chk8("post_data", res_data, v.exp_d);
      cyc();
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      vec_len = 4'd0;
      in_valid = 1'b0;
      in_A = 8'd0;
      in_B = 8'd0;
      res_ready = 1'b0;
      tbl[0] = mk(3, 2, 4, 1, 0, 3, 5, 7, 0, 0, 0, 8'd33, 1'b0);
      tbl[1] = mk(1, 20, 0, 0, 0, 20, 0, 0, 0, 0, 0, 8'd144, 1'b1);
      tbl[2] = mk(2, 3, 2, 0, 0, 3, 2, 0, 0, 5, 4, 8'd13, 1'b0);
      tbl[3] = mk(4, 1, 2, 3, 4, 1, 2, 3, 4, 1, 1, 8'd30, 1'b0);
      repeat (3) cyc();
      @(negedge clk);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_valid", res_valid, 1'b0);
      chk1("rst_dpn", dp_reset_n, 1'b0);
      chk8("rst_data", res_data, 8'd0);
      cyc();
      reset = 1'b0;

      for (int k = 0; k < 4; k++) run_vec(tbl[k]);

      start = 1'b1;
      vec_len = 4'd0;
      @(negedge clk);
      chk1("len0_busy", busy, 1'b0);
      cyc();
      start = 1'b0;
      @(negedge clk);
      chk1("len0_busy2", busy, 1'b0);
      chk1("len0_ready", in_ready, 1'b0);
      cyc();

      start = 1'b1;
      vec_len = 4'd4;
      cyc();
      start = 1'b0;
      in_valid = 1'b1;
      in_A = 8'd1;
      in_B = 8'd2;
      cyc();
      in_A = 8'd3;
      in_B = 8'd4;
      cyc();
      in_A = 8'd5;
      in_B = 8'd6;
      reset = 1'b1;
      @(negedge clk);
      chk1("ar_busy", busy, 1'b0);
      chk1("ar_ready", in_ready, 1'b0);
      chk1("ar_pp", dp_en_PPReg, 1'b0);
      chk1("ar_mux", dp_en_Mux, 1'b0);
      chk1("ar_fd", dp_en_FDReg, 1'b0);
      chk8("ar_A", dp_inData_A, 8'd0);
      chk1("ar_dpn", dp_reset_n, 1'b0);
      chk1("ar_valid", res_valid, 1'b0);
      cyc();
      reset = 1'b0;
      in_valid = 1'b0;
      in_A = 8'd0;
      in_B = 8'd0;
      #1;
      chk1("pr_busy", busy, 1'b0);
      chk8("pr_data", res_data, 8'd0);
      chk1("pr_inv", res_invalid, 1'b0);
      chk1("pr_dpn", dp_reset_n, 1'b1);
      run_vec(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'd1, 1'b0));

      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL sb_left: got %0d want 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dot_product_sequencer.md
DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand width and data_path result width.
REQ-002 Parameter LEN_WIDTH, default 4, width of vector-length field (max length 2^LEN_WIDTH-1).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  pulse; begin a dot product of vec_len elements.
REQ-006 vec_len  input  LEN_WIDTH  element count, sampled with start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 in_valid  input  1  operand pair valid.
REQ-009 in_A, in_B  input  DATA_WIDTH each  operand pair.
REQ-010 in_ready  output  1  sequencer accepts operand pair.
REQ-011 dp_reset_n  output  1  active-low reset for data_path, equal to ~reset.
REQ-012 dp_inData_A, dp_inData_B  output  DATA_WIDTH each  operands to data_path.
REQ-013 dp_en_Mux, dp_en_PPReg, dp_en_FDReg  output  1 each  data_path controls.
REQ-014 dp_outData  input  DATA_WIDTH  data_path final result.
REQ-015 dp_resultIsInvalid  input  1  data_path overflow flag.
REQ-016 res_valid  output  1  result available.
REQ-017 res_ready  input  1  consumer accepts result.
REQ-018 res_data  output  DATA_WIDTH  registered result.
REQ-019 res_invalid  output  1  registered overflow flag.

Function
REQ-020 FSM states SHALL be IDLE, ACCUM, WAIT_FD, HOLD.
REQ-021 IDLE: start=1 and vec_len!=0 -> latch vec_len, clear element count, go ACCUM; start with vec_len=0 ignored, remains IDLE.
REQ-022 start outside IDLE SHALL be ignored with no effect on state or count.
REQ-023 in_ready SHALL be 1 only in ACCUM, combinational from state only (not from in_valid).
REQ-024 Handshake = in_valid & in_ready; only handshake cycles advance the count.
REQ-025 On handshake: dp_inData_A/B = in_A/in_B combinationally, dp_en_PPReg=1, dp_en_Mux = (count!=0), dp_en_FDReg = (count==len-1).
REQ-026 Non-handshake cycles: dp_inData_A/B=0, all dp_en_* = 0 (in_valid=0 stalls in ACCUM indefinitely, accumulator held).
REQ-027 Last handshake (count==len-1) -> WAIT_FD; otherwise count increments by 1.
REQ-028 len=1: single handshake drives dp_en_Mux=0 and dp_en_FDReg=1 together.
REQ-029 WAIT_FD: one cycle; at its end res_data<=dp_outData, res_invalid<=dp_resultIsInvalid; go HOLD.
REQ-030 Latency: res_valid SHALL assert exactly 2 cycles after the last handshake cycle.
REQ-031 HOLD: res_valid=1, res_data/res_invalid stable; res_ready=1 -> IDLE next cycle, res_valid=0.
REQ-032 res_valid SHALL be 0 in IDLE, ACCUM, WAIT_FD; res_data/res_invalid retain last value outside HOLD.
REQ-033 res_ready outside HOLD SHALL be ignored.
REQ-034 start in the HOLD cycle where res_ready=1 SHALL be ignored; a new run requires start in IDLE.

Reset
REQ-035 reset=1 at a rising edge SHALL force IDLE, count=0, latched len=0, res_data=0, res_invalid=0, from any state including mid-ACCUM.
REQ-036 During and after reset: busy=0, in_ready=0, res_valid=0, dp_en_*=0, dp_inData_A/B=0, dp_reset_n=0 while reset=1.
REQ-037 Run aborted by reset produces no result; first post-reset cycle accepts start.

Verification (bench instantiates real data_path on dp_* ports)
REQ-038 start, vec_len=3; pairs (2,3),(4,5),(1,7) back-to-back -> dp_en_Mux 0,1,1; dp_en_FDReg 0,0,1; res_valid 2 cycles after third pair; res_data=33, res_invalid=0.
REQ-039 vec_len=1; pair (20,20) -> en_Mux=0 and en_FDReg=1 same cycle; res_data = low 8 bits of 400, res_invalid=1.
REQ-040 vec_len=2; pair (3,3), in_valid low 5 cycles, pair (2,2) -> dp_en_* all 0 during gap; res_data=13.
REQ-041 Result held with res_ready=0 for 4 cycles, start pulsed meanwhile -> res_valid and res_data=13 stable, start ignored; res_ready=1 -> IDLE, busy=0 next cycle.
REQ-042 vec_len=4, reset after second pair -> next cycle IDLE, all outputs zero; new start vec_len=1 with (1,1) -> res_data=1.
REQ-043 start with vec_len=0 -> busy stays 0, in_ready stays 0.
